alarm_reg_set: RTL and testbench
================================

ALARM_REG_SET -- requirements
Module: alarm_reg_set

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 buttonalam  input  1  alarm mode: 1 = display/edit alarm, 0 = normal time.
REQ-004 btn_hr  input  1  asynchronous push button; increments alarm hours.
REQ-005 btn_min  input  1  asynchronous push button; increments alarm minutes.
REQ-006 alarm_en  input  1  arm switch; 1 = alarm armed.
REQ-007 tick_1hz  input  1  one-clk strobe, once per second, synchronous to clk.
REQ-008 cur_h_t, cur_h_u, cur_m_t, cur_m_u  input  4 each  current time, BCD (hour tens/units, minute tens/units).
REQ-009 al_h_t, al_h_u, al_m_t, al_m_u  output  4 each  stored alarm time, BCD, registered; feeds the display mux alarm leg.
REQ-010 ring  output  1  registered; 1 while alarm sounds.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer plus edge flop; one rising edge = one increment, applied 3 clk cycles after the input rises.
REQ-012 Increments SHALL apply only when buttonalam=1 and state is IDLE; edges at other times SHALL be discarded, not queued.
REQ-013 Minutes SHALL count 00..59 in BCD; 59 -> 00 with no carry into hours.
REQ-014 Hours SHALL count 00..23 in BCD; 23 -> 00; units digit wraps 9 -> 0 with tens +1, except 23 -> 00.
REQ-015 Simultaneous hour and minute edges in one cycle SHALL both apply.
REQ-016 BCD digits SHALL never hold values > 9 (tens: minutes <= 5, hours <= 2).
REQ-017 match = (alarm digits == current digits, all four); match SHALL be registered as match_q each cycle.
REQ-018 States: IDLE, RINGING. IDLE -> RINGING when match=1, match_q=0, alarm_en=1, buttonalam=0 (rising edge of match only).
REQ-019 ring SHALL be 1 exactly while state is RINGING; asserted the cycle after the triggering match edge.
REQ-020 RINGING holds a 6-bit second counter cleared on entry, +1 per tick_1hz; at count 60 -> IDLE.
REQ-021 RINGING -> IDLE on any synchronized edge of btn_hr or btn_min; that edge SHALL NOT increment.
REQ-022 RINGING -> IDLE the cycle after alarm_en=0 is sampled.
REQ-023 After silencing, no re-trigger within the same matching minute (match must drop and rise again).
REQ-024 Multiple exit conditions in one cycle SHALL produce a single transition to IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force: alarm digits 0 (00:00), ring=0, state IDLE, second counter 0, match_q=1, synchronizer/edge flops 0.
REQ-026 match_q reset to 1 SHALL prevent ringing when time is 00:00 at reset release.
REQ-027 Reset asserted mid-ring or mid-edit SHALL abort without any partial increment.

Structure
REQ-028 Shared package/include alarm_pkg SHALL hold state encoding (IDLE, RINGING), MIN_MAX=59, HR_MAX=23, RING_SECS=60.
REQ-029 Sub-module button_edge (sync + rising-edge pulse) SHALL be instantiated once per button.
REQ-030 BCD increment logic and FSM SHALL reside in alarm_reg_set; target 150-300 lines.

Verification
REQ-031 Reset, buttonalam=1, 61 btn_min presses -> al_m = 01 (wrap at 59->00), al_h = 00.
REQ-032 buttonalam=1, 25 btn_hr presses -> al_h = 01; hr+min pressed same cycle from 23:59 -> 00:00.
REQ-033 Alarm 07:30, alarm_en=1, buttonalam=0, cur time changes 07:29 -> 07:30 -> ring=1 next cycle; after 60 tick_1hz -> ring=0.
REQ-034 Ringing, btn_min pressed -> ring=0 within 4 cycles, al_m unchanged; no re-ring while cur stays 07:30.
REQ-035 Ringing, alarm_en -> 0 -> ring=0 next cycle; buttonalam=0 presses -> alarm digits unchanged.
REQ-036 rst_n pulsed low mid-ring with cur=00:00 -> ring=0 at once, alarm 00:00, no ring after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm register set: FSM encoding, counting limits
// and the BCD digit limits derived from them.
package alarm_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } state_t;

    localparam int MIN_MAX   = 59;
    localparam int HR_MAX    = 23;
    localparam int RING_SECS = 60;

    localparam logic [3:0] MIN_T_MAX = 4'(MIN_MAX / 10);
    localparam logic [3:0] MIN_U_MAX = 4'(MIN_MAX % 10);
    localparam logic [3:0] HR_T_MAX  = 4'(HR_MAX / 10);
    localparam logic [3:0] HR_U_MAX  = 4'(HR_MAX % 10);
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer for an asynchronous push button followed by an edge
// flop; o_pulse is high for one clk on each synchronized rising edge.
module button_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/alarm_reg_set.sv
// Alarm time register (BCD HH:MM, button-edited) plus the IDLE/RINGING FSM that
// sounds the alarm on the rising edge of a time match.
module alarm_reg_set
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       buttonalam,
    input  logic       btn_hr,
    input  logic       btn_min,
    input  logic       alarm_en,
    input  logic       tick_1hz,
    input  logic [3:0] cur_h_t,
    input  logic [3:0] cur_h_u,
    input  logic [3:0] cur_m_t,
    input  logic [3:0] cur_m_u,
    output logic [3:0] al_h_t,
    output logic [3:0] al_h_u,
    output logic [3:0] al_m_t,
    output logic [3:0] al_m_u,
    output logic       ring,
    output state_t     dbg_state
);

    logic       w_hr_pulse;
    logic       w_min_pulse;
    logic       w_match;
    logic       w_edit_hr;
    logic       w_edit_min;
    logic [3:0] w_h_t_next;
    logic [3:0] w_h_u_next;
    logic [3:0] w_m_t_next;
    logic [3:0] w_m_u_next;
    logic [5:0] w_sec_next;
    state_t     w_state_next;

    logic [3:0] r_al_h_t;
    logic [3:0] r_al_h_u;
    logic [3:0] r_al_m_t;
    logic [3:0] r_al_m_u;
    logic       r_match_q;
    logic [5:0] r_sec;
    state_t     r_state;

    button_edge u_btn_hr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_hr),
        .o_pulse (w_hr_pulse)
    );

    button_edge u_btn_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_min),
        .o_pulse (w_min_pulse)
    );

    assign w_match = ({r_al_h_t, r_al_h_u, r_al_m_t, r_al_m_u} ==
                      {cur_h_t, cur_h_u, cur_m_t, cur_m_u});

    // Edges outside edit mode, or while ringing, are dropped rather than queued.
    assign w_edit_hr  = w_hr_pulse  && buttonalam && (r_state == IDLE);
    assign w_edit_min = w_min_pulse && buttonalam && (r_state == IDLE);

    always_comb begin
        w_h_t_next = r_al_h_t;
        w_h_u_next = r_al_h_u;
        if (w_edit_hr) begin
            if (r_al_h_t == HR_T_MAX && r_al_h_u == HR_U_MAX) begin
                w_h_t_next = 4'd0;
                w_h_u_next = 4'd0;
            end else if (r_al_h_u == BCD_MAX) begin
                w_h_t_next = r_al_h_t + 4'd1;
                w_h_u_next = 4'd0;
            end else begin
                w_h_u_next = r_al_h_u + 4'd1;
            end
        end
    end

    // Minutes wrap 59 -> 00 on their own; no carry into the hour digits.
    always_comb begin
        w_m_t_next = r_al_m_t;
        w_m_u_next = r_al_m_u;
        if (w_edit_min) begin
            if (r_al_m_u == MIN_U_MAX) begin
                w_m_u_next = 4'd0;
                w_m_t_next = (r_al_m_t == MIN_T_MAX) ? 4'd0 : r_al_m_t + 4'd1;
            end else begin
                w_m_u_next = r_al_m_u + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sec_next   = r_sec;
        case (r_state)
            IDLE: begin
                w_sec_next = 6'd0;
                if (w_match && !r_match_q && alarm_en && !buttonalam) begin
                    w_state_next = RINGING;
                end
            end
            RINGING: begin
                if (tick_1hz) begin
                    w_sec_next = r_sec + 6'd1;
                end
                // All exit causes funnel into one assignment, so coincident ones
                // still give a single return to IDLE.
                if (w_hr_pulse || w_min_pulse || !alarm_en ||
                    (tick_1hz && r_sec == RING_LAST)) begin
                    w_state_next = IDLE;
                    w_sec_next   = 6'd0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_sec_next   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sec   <= 6'd0;
        end else begin
            r_state <= w_state_next;
            r_sec   <= w_sec_next;
        end
    end

    // match_q resets high so a 00:00 current time at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_q <= 1'b1;
        end else begin
            r_match_q <= w_match;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_al_h_t <= 4'd0;
            r_al_h_u <= 4'd0;
            r_al_m_t <= 4'd0;
            r_al_m_u <= 4'd0;
        end else begin
            r_al_h_t <= w_h_t_next;
            r_al_h_u <= w_h_u_next;
            r_al_m_t <= w_m_t_next;
            r_al_m_u <= w_m_u_next;
        end
    end

    assign al_h_t    = r_al_h_t;
    assign al_h_u    = r_al_h_u;
    assign al_m_t    = r_al_m_t;
    assign al_m_u    = r_al_m_u;
    assign ring      = (r_state == RINGING);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alarm_reg_set.sv
// Self-checking bench for alarm_reg_set: press-count vector table, hand-written
// ring/silence/reset sequences, and randomized edits/matches against a model.
module tb_alarm_reg_set;
    import alarm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       buttonalam;
    logic       btn_hr;
    logic       btn_min;
    logic       alarm_en;
    logic       tick_1hz;
    logic [3:0] cur_h_t, cur_h_u, cur_m_t, cur_m_u;
    logic [3:0] al_h_t, al_h_u, al_m_t, al_m_u;
    logic       ring;
    state_t     dbg_state;

    int n_checks = 0;
    int n_passed = 0;

    // Reference model: alarm time as plain integers.
    int m_hr;
    int m_min;

    typedef struct {
        int          n_hr;
        int          n_min;
        logic [15:0] exp_al;
    } vec_t;

    vec_t vecs[8];

    alarm_reg_set dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttonalam (buttonalam),
        .btn_hr     (btn_hr),
        .btn_min    (btn_min),
        .alarm_en   (alarm_en),
        .tick_1hz   (tick_1hz),
        .cur_h_t    (cur_h_t),
        .cur_h_u    (cur_h_u),
        .cur_m_t    (cur_m_t),
        .cur_m_u    (cur_m_u),
        .al_h_t     (al_h_t),
        .al_h_u     (al_h_u),
        .al_m_t     (al_m_t),
        .al_m_u     (al_m_u),
        .ring       (ring),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_time(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] al_now();
        return {al_h_t, al_h_u, al_m_t, al_m_u};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_cur(input int h, input int m);
        {cur_h_t, cur_h_u, cur_m_t, cur_m_u} = bcd_time(h, m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic hr, input logic mn);
        @(negedge clk);
        btn_hr  = hr;
        btn_min = mn;
        repeat (3) @(negedge clk);
        btn_hr  = 1'b0;
        btn_min = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_n(input int nh, input int nm);
        int both;
        both = (nh < nm) ? nh : nm;
        for (int i = 0; i < both; i++) press(1'b1, 1'b1);
        for (int i = 0; i < nh - both; i++) press(1'b1, 1'b0);
        for (int i = 0; i < nm - both; i++) press(1'b0, 1'b1);
    endtask

    task automatic tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic trigger_0730(input string name);
        @(negedge clk);
        set_cur(7, 29);
        repeat (2) @(negedge clk);
        set_cur(7, 30);
        @(negedge clk);
        check(name, 16'(ring), 16'd1);
    endtask

    initial begin
        logic prev_match;
        logic ringing;
        logic match;
        int   ch, cm, r;

        rst_n = 1'b1; buttonalam = 1'b0; btn_hr = 1'b0; btn_min = 1'b0;
        alarm_en = 1'b0; tick_1hz = 1'b0;
        set_cur(12, 34);

        vecs[0] = '{0, 61, 16'h0001};
        vecs[1] = '{25, 0, 16'h0100};
        vecs[2] = '{23, 59, 16'h2359};
        vecs[3] = '{24, 60, 16'h0000};
        vecs[4] = '{12, 10, 16'h1210};
        vecs[5] = '{9, 9, 16'h0909};
        vecs[6] = '{10, 10, 16'h1010};
        vecs[7] = '{19, 45, 16'h1945};

        // Reset state
        do_reset();
        check("reset_alarm", al_now(), 16'h0000);
        check("reset_ring", 16'(ring), 16'd0);
        check("reset_state", 16'(dbg_state), 16'(IDLE));

        // Press-count vectors, each from a fresh reset
        buttonalam = 1'b1;
        for (int v = 0; v < 8; v++) begin
            do_reset();
            press_n(vecs[v].n_hr, vecs[v].n_min);
            check($sformatf("vec%0d_alarm", v), al_now(), vecs[v].exp_al);
        end

        // 23:59 -> simultaneous hr+min -> 00:00
        do_reset();
        press_n(23, 59);
        press(1'b1, 1'b1);
        check("wrap_both", al_now(), 16'h0000);

        // Ring for 60 ticks
        do_reset();
        press_n(7, 30);
        check("set_0730", al_now(), 16'h0730);
        @(negedge clk);
        buttonalam = 1'b0;
        alarm_en   = 1'b1;
        set_cur(7, 29);
        repeat (2) @(negedge clk);
        check("no_ring_0729", 16'(ring), 16'd0);
        trigger_0730("ring_on_match");
        for (int i = 0; i < 59; i++) tick();
        check("ring_after_59", 16'(ring), 16'd1);
        tick();
        @(negedge clk);
        check("ring_off_60", 16'(ring), 16'd0);
        repeat (10) @(negedge clk);
        check("no_rering_timeout", 16'(ring), 16'd0);

        // Silence by button while in edit mode: the edge must not increment
        trigger_0730("ring_again");
        buttonalam = 1'b1;
        btn_min    = 1'b1;
        repeat (4) @(negedge clk);
        check("btn_silence", 16'(ring), 16'd0);
        btn_min = 1'b0;
        repeat (4) @(negedge clk);
        check("btn_no_incr", al_now(), 16'h0730);
        buttonalam = 1'b0;
        repeat (10) @(negedge clk);
        check("no_rering_btn", 16'(ring), 16'd0);

        // Silence by disarming
        trigger_0730("ring_third");
        alarm_en = 1'b0;
        @(negedge clk);
        check("disarm_silence", 16'(ring), 16'd0);
        press_n(3, 3);
        check("normal_mode_presses", al_now(), 16'h0730);

        // Reset mid-ring with current time 00:00
        set_cur(0, 1);
        do_reset();
        alarm_en = 1'b1;
        repeat (2) @(negedge clk);
        set_cur(0, 0);
        @(negedge clk);
        check("ring_0000", 16'(ring), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ring", 16'(ring), 16'd0);
        check("async_reset_state", 16'(dbg_state), 16'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_ring_after_rst", 16'(ring), 16'd0);
        check("alarm_after_rst", al_now(), 16'h0000);

        // Reset mid-edit: a pending edge must be lost
        buttonalam = 1'b1;
        @(negedge clk);
        btn_min = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        btn_min = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("edit_abort", al_now(), 16'h0000);

        // Randomized edits against the integer model
        m_hr = 0; m_min = 0;
        set_cur(12, 34);
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 2);
            press(r != 1, r != 0);
            if (r != 1) m_hr = (m_hr + 1) % (HR_MAX + 1);
            if (r != 0) m_min = (m_min + 1) % (MIN_MAX + 1);
            check($sformatf("rand_edit%0d", i), al_now(), bcd_time(m_hr, m_min));
        end

        // Randomized current times / arm state against the ring rule
        @(negedge clk);
        buttonalam = 1'b0;
        alarm_en   = 1'b1;
        set_cur(m_hr, (m_min + 1) % 60);
        repeat (2) @(negedge clk);
        prev_match = 1'b0;
        ringing    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) < 2) begin
                ch = m_hr; cm = m_min;
            end else begin
                ch = $urandom_range(0, 23); cm = $urandom_range(0, 59);
            end
            set_cur(ch, cm);
            alarm_en = ($urandom_range(0, 4) != 0);
            match = (ch == m_hr) && (cm == m_min);
            if (ringing) ringing = alarm_en;
            else ringing = match && !prev_match && alarm_en;
            prev_match = match;
            @(negedge clk);
            check($sformatf("rand_ring%0d", i), 16'(ring), 16'(ringing));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
